// File: rtl/xport_arbiter.sv
// xport_arbiter
// Shares the X-SRAM read port between two burst requesters (A: weight-buffer
// send engine, B: input-feature fetch) and turns each granted burst into a
// stream of single-word reads.
//
// Ports:
//   CLK, RST (async, active-high), PURGE (sync clear, same effect as RST)
//   MBUSYXI                : X-SRAM busy, no read issues while high
//   REQx/ADDRx/LENx        : burst request, start address, word count (0 = 2^LW)
//   GNTx                   : one-cycle pulse, burst accepted
//   VALIDx                 : read data on the X-SRAM bus belongs to requester x
//   DONEx                  : coincides with the last VALIDx of a burst
//   RADDRX/RCEBX           : X-SRAM read address / active-low read enable
//   BUSY                   : arbiter is not idle
module xport_arbiter #(
    parameter int AW = 16,
    parameter int LW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PURGE,
    input  logic          MBUSYXI,
    input  logic          REQA,
    input  logic [AW-1:0] ADDRA,
    input  logic [LW-1:0] LENA,
    output logic          GNTA,
    output logic          VALIDA,
    output logic          DONEA,
    input  logic          REQB,
    input  logic [AW-1:0] ADDRB,
    input  logic [LW-1:0] LENB,
    output logic          GNTB,
    output logic          VALIDB,
    output logic          DONEB,
    output logic [AW-1:0] RADDRX,
    output logic          RCEBX,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam logic [LW:0] REM_ONE  = {{LW{1'b0}}, 1'b1};
    localparam logic [LW:0] REM_FULL = {1'b1, {LW{1'b0}}};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW:0]   remaining_q, remaining_d;
    logic          gnta_q, gnta_d;
    logic          gntb_q, gntb_d;
    logic          valida_q, valida_d;
    logic          validb_q, validb_d;
    logic          donea_q, donea_d;
    logic          doneb_q, doneb_d;

    logic          issue;
    logic          grant_b;
    logic [LW-1:0] len_sel;

    // A read goes out in any RUN cycle the macro is not busy.
    assign issue = (state_q == RUN) && !MBUSYXI;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        gnta_d      = 1'b0;
        gntb_d      = 1'b0;
        valida_d    = 1'b0;
        validb_d    = 1'b0;
        donea_d     = 1'b0;
        doneb_d     = 1'b0;
        grant_b     = 1'b0;
        len_sel     = LENA;

        case (state_q)
            IDLE: begin
                if (REQA || REQB) begin
                    // B wins when it is alone, or when both ask and A went last.
                    grant_b     = REQB && (!REQA || (last_q == OWN_A));
                    len_sel     = grant_b ? LENB : LENA;
                    owner_d     = grant_b;
                    last_d      = grant_b;
                    cur_addr_d  = grant_b ? ADDRB : ADDRA;
                    remaining_d = (len_sel == '0) ? REM_FULL : {1'b0, len_sel};
                    gnta_d      = !grant_b;
                    gntb_d      = grant_b;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    valida_d    = (owner_q == OWN_A);
                    validb_d    = (owner_q == OWN_B);
                    donea_d     = (remaining_q == REM_ONE) && (owner_q == OWN_A);
                    doneb_d     = (remaining_q == REM_ONE) && (owner_q == OWN_B);
                    if (remaining_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // PURGE overrides everything, including dropping the read in flight.
        if (PURGE) begin
            state_d     = IDLE;
            owner_d     = OWN_A;
            last_d      = OWN_B;
            cur_addr_d  = '0;
            remaining_d = '0;
            gnta_d      = 1'b0;
            gntb_d      = 1'b0;
            valida_d    = 1'b0;
            validb_d    = 1'b0;
            donea_d     = 1'b0;
            doneb_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_A;
            last_q      <= OWN_B;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            gnta_q      <= 1'b0;
            gntb_q      <= 1'b0;
            valida_q    <= 1'b0;
            validb_q    <= 1'b0;
            donea_q     <= 1'b0;
            doneb_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            gnta_q      <= gnta_d;
            gntb_q      <= gntb_d;
            valida_q    <= valida_d;
            validb_q    <= validb_d;
            donea_q     <= donea_d;
            doneb_q     <= doneb_d;
        end
    end

    assign GNTA   = gnta_q;
    assign GNTB   = gntb_q;
    assign VALIDA = valida_q;
    assign VALIDB = validb_q;
    assign DONEA  = donea_q;
    assign DONEB  = doneb_q;
    assign RADDRX = cur_addr_q;
    assign RCEBX  = !issue;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_xport_arbiter.sv
module tb_xport_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        purge = 1'b0;
    logic        mbusy = 1'b0;
    logic        REQA = 1'b0, REQB = 1'b0;
    logic [15:0] ADDRA = '0, ADDRB = '0;
    logic [7:0]  LENA = '0, LENB = '0;
    logic        GNTA, VALIDA, DONEA, GNTB, VALIDB, DONEB;
    logic [15:0] RADDRX;
    logic        RCEBX, BUSY;

    xport_arbiter #(.AW(16), .LW(8)) dut (
        .CLK(clk), .RST(rst), .PURGE(purge), .MBUSYXI(mbusy),
        .REQA(REQA), .ADDRA(ADDRA), .LENA(LENA),
        .GNTA(GNTA), .VALIDA(VALIDA), .DONEA(DONEA),
        .REQB(REQB), .ADDRB(ADDRB), .LENB(LENB),
        .GNTB(GNTB), .VALIDB(VALIDB), .DONEB(DONEB),
        .RADDRX(RADDRX), .RCEBX(RCEBX), .BUSY(BUSY)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [7:0] len; } req_t;
    typedef struct { int cyc; logic [15:0] addr; } iss_t;
    typedef struct { int cyc; bit own_b; bit done; } val_t;
    typedef struct { int cyc; bit own_b; } gnt_t;

    req_t qa[$], qb[$];
    iss_t iss_q[$];
    val_t val_q[$];
    gnt_t gnt_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: the active burst is just the list of addresses still to read.
    int          m_phase = 0;   // 0 idle, 1 reading, 2 one-cycle tail
    logic [15:0] m_words[$];
    bit          m_owner = 0;
    bit          m_last = 1;
    bit          exp_busy = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic miss(string name, int when);
        n_cmp++;
        n_bad++;
        $display("FAIL %s cyc=%0d expected event at cyc %0d never seen", name, cyc, when);
    endtask

    task automatic reset_model();
        m_phase = 0;
        m_words.delete();
        m_last  = 1;
        m_owner = 0;
        iss_q.delete();
        val_q.delete();
        gnt_q.delete();
        exp_busy = 0;
    endtask

    // Requester agents: hold REQ with stable address until granted.
    initial forever begin
        @(posedge clk); #1;
        if (REQA && GNTA) begin
            REQA = 1'b0;
            void'(qa.pop_front());
        end else if (!REQA && qa.size() > 0) begin
            ADDRA = qa[0].addr; LENA = qa[0].len; REQA = 1'b1;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (REQB && GNTB) begin
            REQB = 1'b0;
            void'(qb.pop_front());
        end else if (!REQB && qb.size() > 0) begin
            ADDRB = qb[0].addr; LENB = qb[0].len; REQB = 1'b1;
        end
    end

    // Predictor: after the inputs for this cycle settle, work out what the
    // port must do this cycle and what follows next cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
        #3;
        if (rst) begin
            reset_model();
        end else begin
            exp_busy = (m_phase != 0);
            case (m_phase)
                0: if (!purge && (REQA || REQB)) begin
                    bit          who;
                    logic [7:0]  len;
                    logic [15:0] base;
                    int          n;
                    who  = REQB && (!REQA || !m_last);
                    len  = who ? LENB : LENA;
                    base = who ? ADDRB : ADDRA;
                    n    = (len == 0) ? 256 : int'(len);
                    for (int i = 0; i < n; i++) m_words.push_back(base + 16'(i));
                    gnt_q.push_back('{cyc + 1, who});
                    m_owner = who;
                    m_last  = who;
                    m_phase = 1;
                end
                1: if (!mbusy) begin
                    logic [15:0] a;
                    a = m_words.pop_front();
                    iss_q.push_back('{cyc, a});
                    if (!purge) val_q.push_back('{cyc + 1, m_owner, m_words.size() == 0});
                    if (m_words.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            if (purge) begin
                m_phase = 0;
                m_words.delete();
                m_last = 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output.
    initial forever begin
        @(negedge clk);
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin miss("issue", iss_q[0].cyc); void'(iss_q.pop_front()); end
        while (val_q.size() > 0 && val_q[0].cyc < cyc) begin miss("valid", val_q[0].cyc); void'(val_q.pop_front()); end
        while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin miss("grant", gnt_q[0].cyc); void'(gnt_q.pop_front()); end

        check("busy", int'(BUSY), int'(exp_busy));

        begin
            bit e;
            e = iss_q.size() > 0 && iss_q[0].cyc == cyc;
            check("rceb", int'(RCEBX), int'(!e));
            if (e) begin
                if (!RCEBX) check("raddr", int'(RADDRX), int'(iss_q[0].addr));
                void'(iss_q.pop_front());
            end
        end

        begin
            bit [1:0] ev, ed;
            ev = 2'b00; ed = 2'b00;
            if (val_q.size() > 0 && val_q[0].cyc == cyc) begin
                ev = val_q[0].own_b ? 2'b01 : 2'b10;
                if (val_q[0].done) ed = ev;
                void'(val_q.pop_front());
            end
            check("valid_ab", int'({VALIDA, VALIDB}), int'(ev));
            check("done_ab", int'({DONEA, DONEB}), int'(ed));
        end

        begin
            bit [1:0] eg;
            eg = 2'b00;
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                eg = gnt_q[0].own_b ? 2'b01 : 2'b10;
                void'(gnt_q.pop_front());
            end
            check("gnt_ab", int'({GNTA, GNTB}), int'(eg));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(int budget);
        int k;
        k = 0;
        while ((qa.size() > 0 || qb.size() > 0 || REQA || REQB || BUSY || exp_busy ||
                iss_q.size() > 0 || val_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) miss("idle_timeout", cyc);
        tick();
        tick();
    endtask

    task automatic wait_gnt(bit b);
        int k;
        k = 0;
        while (!(b ? GNTB : GNTA) && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) miss("gnt_timeout", cyc);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_gnt"},   int'({GNTA, GNTB}), 0);
        check({tag, "_valid"}, int'({VALIDA, VALIDB}), 0);
        check({tag, "_done"},  int'({DONEA, DONEB}), 0);
        check({tag, "_busy"},  int'(BUSY), 0);
        check({tag, "_rceb"},  int'(RCEBX), 1);
        check({tag, "_raddr"}, int'(RADDRX), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic 4-word burst from A.
        qa.push_back('{16'h0100, 8'd4});
        wait_idle(100);

        // Both requesting continuously: strict alternation A, B, A, B.
        qa.push_back('{16'h1000, 8'd2}); qa.push_back('{16'h1100, 8'd2});
        qb.push_back('{16'h2000, 8'd2}); qb.push_back('{16'h2100, 8'd2});
        wait_idle(200);

        // Two stall cycles right after the first issue.
        qa.push_back('{16'h0200, 8'd3});
        wait_gnt(1'b0);
        mbusy = 1'b0; tick();
        mbusy = 1'b1; tick();
        mbusy = 1'b1; tick();
        mbusy = 1'b0;
        wait_idle(100);

        // Address wrap across FFFF.
        qb.push_back('{16'hFFFE, 8'd3});
        wait_idle(100);

        // LEN == 0 means 256 words.
        qa.push_back('{16'h1234, 8'd0});
        wait_idle(1000);

        // PURGE on the second issue of an 8-word burst, then both ask.
        qa.push_back('{16'h0300, 8'd8});
        wait_gnt(1'b0);
        tick();
        purge = 1'b1; tick();
        purge = 1'b0;
        qb.push_back('{16'h0400, 8'd2});
        qa.push_back('{16'h0500, 8'd1});
        wait_idle(100);

        // Asynchronous reset in the middle of a burst, checked between edges.
        qb.push_back('{16'h0600, 8'd6});
        wait_gnt(1'b1);
        tick();
        tick();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick();
        tick();
        rst = 1'b0;
        wait_idle(100);

        // Randomized traffic with stalls and occasional purges.
        for (int i = 0; i < 400; i++) begin
            mbusy = ($urandom_range(0, 3) == 0);
            purge = ($urandom_range(0, 79) == 0);
            if (qa.size() < 2 && $urandom_range(0, 7) == 0)
                qa.push_back('{16'($urandom), 8'($urandom_range(1, 7))});
            if (qb.size() < 2 && $urandom_range(0, 7) == 0)
                qb.push_back('{16'($urandom), 8'($urandom_range(1, 7))});
            tick();
        end
        mbusy = 1'b0;
        purge = 1'b0;
        wait_idle(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
